// File: rtl/key_note_pkg.sv
// Shared definitions for the keyboard-to-note controller: note codes,
// PS/2 prefix bytes, parser states and the note-code classifier.
package key_note_pkg;

    localparam int NUM_NOTES = 24;

    localparam logic [7:0] NOTE_CODES [NUM_NOTES] = '{
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
        8'h44, 8'h4D, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33,
        8'h3B, 8'h42, 8'h4B, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31
    };

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parse_state_t;

    function automatic logic is_note(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            hit = hit | (code == NOTE_CODES[i]);
        end
        return hit;
    endfunction

endpackage

// File: rtl/key_note_ctrl_stack.sv
// Held-key stack: index 0 is the oldest key, index count-1 the newest.
// Exposes next-state top/count so the parent can register its outputs.
module key_stack
    #(
        parameter int STACK_DEPTH = 4,
        parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
    )
    (
        input  logic             clk,
        input  logic             rst,
        input  logic             make_ev,
        input  logic             brk_ev,
        input  logic [7:0]       key,
        output logic [7:0]       top_nxt,
        output logic [CNT_W-1:0] cnt_nxt,
        output logic             evict
    );

    logic [7:0]             stk_r     [STACK_DEPTH];
    logic [7:0]             stk_nxt_s [STACK_DEPTH];
    logic [7:0]             upper_s   [STACK_DEPTH];
    logic [CNT_W-1:0]       cnt_r;
    logic [STACK_DEPTH-1:0] hit_vec_s;
    logic                   hit_s;
    logic                   full_s;
    logic                   seen_s;

    // Next-state stack contents: push, evict-oldest, or remove-and-compact.
    always_comb begin
        stk_nxt_s = stk_r;
        cnt_nxt   = cnt_r;
        evict     = 1'b0;
        seen_s    = 1'b0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            hit_vec_s[i] = (CNT_W'(i) < cnt_r) && (stk_r[i] == key);
        end
        for (int i = 0; i < STACK_DEPTH - 1; i++) begin
            upper_s[i] = stk_r[i + 1];
        end
        upper_s[STACK_DEPTH-1] = 8'h00;
        hit_s  = |hit_vec_s;
        full_s = (cnt_r == CNT_W'(STACK_DEPTH));

        if (make_ev && !hit_s) begin
            if (full_s) begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    stk_nxt_s[i] = upper_s[i];
                end
                stk_nxt_s[STACK_DEPTH-1] = key;
                evict = 1'b1;
            end else begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    stk_nxt_s[i] = (CNT_W'(i) == cnt_r) ? key : stk_r[i];
                end
                cnt_nxt = cnt_r + CNT_W'(1);
            end
        end else if (brk_ev && hit_s) begin
            // Everything from the matched slot upward slides down one place.
            for (int i = 0; i < STACK_DEPTH; i++) begin
                seen_s       = seen_s | hit_vec_s[i];
                stk_nxt_s[i] = seen_s ? upper_s[i] : stk_r[i];
            end
            cnt_nxt = cnt_r - CNT_W'(1);
        end else begin
            cnt_nxt = cnt_r;
        end

        top_nxt = 8'h00;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            top_nxt = (CNT_W'(i + 1) == cnt_nxt) ? stk_nxt_s[i] : top_nxt;
        end
    end

    // Stack storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_r[i] <= 8'h00;
            end
        end else begin
            cnt_r <= cnt_nxt;
            stk_r <= stk_nxt_s;
        end
    end

endmodule

// File: rtl/key_note_ctrl.sv
// PS/2 scan-code parser driving a last-note-priority key stack.
// Define KEY_NOTE_SUSTAIN_EN to hold the last note for RELEASE_MS after release.
module key_note_ctrl
    import key_note_pkg::*;
    #(
        parameter int STACK_DEPTH = 4,
        parameter int CLK_HZ      = 100_000_000,
        parameter int RELEASE_MS  = 50
    )
    (
        input  logic                               clk,
        input  logic                               rst,
        input  logic [7:0]                         scan_code,
        input  logic                               scan_valid,
        output logic [7:0]                         codigo,
        output logic                               note_on,
        output logic [$clog2(STACK_DEPTH+1)-1:0]   held_count,
        output logic                               overflow
    );

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    parse_state_t     state_r;
    parse_state_t     state_nxt_s;
    logic             make_s;
    logic             brk_s;
    logic [7:0]       top_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             evict_s;
    logic [7:0]       codigo_r;
    logic             note_on_r;
    logic [CNT_W-1:0] held_count_r;
    logic             overflow_r;

    // Prefix parser: decodes make/break events for note codes.
    always_comb begin
        state_nxt_s = state_r;
        make_s      = 1'b0;
        brk_s       = 1'b0;
        if (scan_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (scan_code == CODE_BRK) begin
                        state_nxt_s = ST_BRK;
                    end else if (scan_code == CODE_EXT) begin
                        state_nxt_s = ST_EXT;
                    end else begin
                        make_s      = is_note(scan_code);
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    brk_s       = is_note(scan_code);
                    state_nxt_s = ST_IDLE;
                end
                ST_EXT: begin
                    state_nxt_s = (scan_code == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    key_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .CNT_W       (CNT_W)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .make_ev (make_s),
        .brk_ev  (brk_s),
        .key     (scan_code),
        .top_nxt (top_nxt_s),
        .cnt_nxt (cnt_nxt_s),
        .evict   (evict_s)
    );

`ifdef KEY_NOTE_SUSTAIN_EN
    localparam longint unsigned SUS_CYC = 64'(RELEASE_MS) * 64'(CLK_HZ) / 64'd1000;
    localparam int SUS_W = (SUS_CYC > 64'd0) ? $clog2(SUS_CYC + 64'd1) : 1;

    logic [SUS_W-1:0] sus_cnt_r;

    // Parser state and output registers; an emptying break starts the sustain timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            codigo_r     <= 8'h00;
            note_on_r    <= 1'b0;
            held_count_r <= '0;
            overflow_r   <= 1'b0;
            sus_cnt_r    <= '0;
        end else begin
            state_r      <= state_nxt_s;
            held_count_r <= cnt_nxt_s;
            overflow_r   <= overflow_r | evict_s;
            if (cnt_nxt_s != '0) begin
                codigo_r  <= top_nxt_s;
                note_on_r <= 1'b1;
                sus_cnt_r <= '0;
            end else if (held_count_r != '0) begin
                codigo_r  <= (SUS_CYC == 64'd0) ? 8'h00 : codigo_r;
                note_on_r <= (SUS_CYC != 64'd0);
                sus_cnt_r <= SUS_W'(SUS_CYC);
            end else if (sus_cnt_r > SUS_W'(1)) begin
                sus_cnt_r <= sus_cnt_r - SUS_W'(1);
            end else begin
                codigo_r  <= 8'h00;
                note_on_r <= 1'b0;
                sus_cnt_r <= '0;
            end
        end
    end
`else
    // Parser state and output registers tracking the stack top directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            codigo_r     <= 8'h00;
            note_on_r    <= 1'b0;
            held_count_r <= '0;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            held_count_r <= cnt_nxt_s;
            overflow_r   <= overflow_r | evict_s;
            codigo_r     <= top_nxt_s;
            note_on_r    <= (top_nxt_s != 8'h00);
        end
    end
`endif

    assign codigo     = codigo_r;
    assign note_on    = note_on_r;
    assign held_count = held_count_r;
    assign overflow   = overflow_r;

endmodule

// File: doc/key_note_ctrl.md
KEY_NOTE_CTRL -- requirements
Module: key_note_ctrl

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, maximum number of simultaneously held note keys tracked.
REQ-002 SHALL have parameter CLK_HZ, default 100_000_000, clk frequency in Hz.
REQ-003 SHALL have parameter RELEASE_MS, default 50, sustain time in ms (used only with REQ-030).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port scan_code  input  8  PS/2 scan code byte from the keyboard receiver.
REQ-007 SHALL have port scan_valid  input  1  one-cycle strobe; scan_code is valid in that cycle.
REQ-008 SHALL have port codigo  output  8  note scan code to the sine generator; 8'h00 means silence.
REQ-009 SHALL have port note_on  output  1  high while codigo is non-zero.
REQ-010 SHALL have port held_count  output  $clog2(STACK_DEPTH+1)  number of note keys currently held.
REQ-011 SHALL have port overflow  output  1  sticky; set when a push evicts the oldest key.

Function
REQ-012 Note set SHALL be exactly these 24 codes: 15,1D,24,2D,2C,35,3C,43,44,4D,1C,1B,23,2B,34,33,3B,42,4B,22,21,2A,32,31 (hex); every other code is a non-note code.
REQ-013 Parser FSM SHALL have states IDLE, BRK (F0 received), EXT (E0 received), EXT_BRK (E0 F0 received).
REQ-014 IDLE: F0 -> BRK; E0 -> EXT; note code -> make event, stay IDLE; other codes -> ignored, stay IDLE.
REQ-015 BRK: any code -> break event for that code if it is a note, then IDLE.
REQ-016 EXT: F0 -> EXT_BRK; any other code -> ignored, then IDLE. EXT_BRK: any code -> ignored, then IDLE.
REQ-017 FSM SHALL advance only in cycles with scan_valid=1; otherwise it holds state.
REQ-018 Make of a key already in the stack (typematic repeat) SHALL leave stack and outputs unchanged.
REQ-019 Make of a new key SHALL push it on top; if held_count==STACK_DEPTH the oldest entry SHALL be dropped, the others shifted down, and overflow set.
REQ-020 Break of a held key SHALL remove it from any position, compacting the entries above it down by one and preserving order.
REQ-021 Break of a key not in the stack SHALL be ignored.
REQ-022 codigo SHALL equal the top-of-stack (last-pressed held key) or 8'h00 when the stack is empty; last-note priority.
REQ-023 codigo, note_on and held_count SHALL be registered and update exactly one clk cycle after the scan_valid cycle that caused the change.
REQ-024 overflow SHALL stay set until rst.

Reset
REQ-025 rst=1 SHALL, on the next rising clk edge, set the FSM to IDLE, empty the stack, and force codigo=8'h00, note_on=0, held_count=0 and overflow=0.
REQ-026 rst SHALL take priority over a scan_valid in the same cycle; that byte is discarded.
REQ-027 rst asserted mid-sequence (after F0 or E0) SHALL discard the pending prefix.

Configuration
REQ-028 Macro KEY_NOTE_SUSTAIN_EN SHALL select the sustain feature.
REQ-029 Without the macro, codigo SHALL go to 8'h00 one cycle after the break that empties the stack.
REQ-030 With the macro, when the stack empties, codigo SHALL hold the last note for RELEASE_MS*CLK_HZ/1000 cycles, then go to 8'h00; note_on SHALL stay high during sustain.
REQ-031 With the macro, a make during sustain SHALL cancel the sustain and output the new key one cycle later; rst SHALL cancel sustain.

Structure
REQ-032 Shared package key_note_pkg SHALL hold the 24 note-code constants, the F0/E0 prefix constants, the parser-state enum, and an is_note function.
REQ-033 Stack storage and push/remove/compact logic SHALL be sub-module key_stack, parameterised by STACK_DEPTH.
REQ-034 The sustain counter SHALL be sized by $clog2 of the cycle count and excluded when the macro is undefined.

Verification
REQ-035 Bench SHALL cover: 1C -> codigo=1C, note_on=1, held_count=1; F0 1C -> codigo=00, note_on=0.
REQ-036 Bench SHALL cover: 15,1D,24 held, then F0 1D -> codigo=24, held_count=2; then F0 24 -> codigo=15.
REQ-037 Bench SHALL cover: 15,1D,24,2D,2C (depth 4) -> codigo=2C, held_count=4, overflow=1; F0 15 -> no change.
REQ-038 Bench SHALL cover: E0 1C, E0 F0 1C, and 1C repeated 3x -> only one 1C is held; E0-prefixed bytes change nothing.
REQ-039 Bench SHALL cover: F0 then rst then 1C -> codigo=1C, showing the F0 was discarded; 5A (non-note) -> ignored.
REQ-040 Bench SHALL cover, with KEY_NOTE_SUSTAIN_EN and RELEASE_MS=1: 1C, F0 1C -> codigo=1C for CLK_HZ/1000 cycles, then 00; a make 15 mid-sustain -> codigo=15 next cycle.
